// File: rtl/mesh_pkg.sv
// Shared types and constants for the shear-sort mesh: scheduler state
// encoding, phase-type constants used by the PE decode, phase-count helper.
package mesh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam logic PHASE_ROW = 1'b1;
  localparam logic PHASE_COL = 1'b0;

  // Per-step flags broadcast to every PE alongside the phase/step indices.
  typedef struct packed {
    logic row;
    logic odd;
    logic snake;
  } cmd_flags_t;

  // log2(side) column passes interleaved with log2(side)+1 row passes.
  function automatic int unsigned shear_phases(input int unsigned side);
    return 32'(2 * $clog2(side) + 1);
  endfunction

endpackage

// File: rtl/mesh_wrap_cnt.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the enabled
// cycle on which the count returns to zero.
module mesh_wrap_cnt #(
  parameter  int unsigned MOD = 4,
  localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = en && (q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= wrap ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/shear_sched.sv
// Shear-sort phase/step scheduler: walks alternating row/column odd-even
// transposition phases, one compare-exchange command per accepted step.
module shear_sched
  import mesh_pkg::*;
#(
  parameter  int unsigned N           = 4,
  parameter  int unsigned SIDE        = 2,
  parameter  int unsigned SORT_CYCLES = 4,
  localparam int unsigned PHASES      = shear_phases(SIDE),
  localparam int unsigned PW          = $clog2(PHASES),
  localparam int unsigned SW          = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cmd_valid,
  input  logic          pe_ready,
  output logic          cmd_row,
  output logic          cmd_odd,
  output logic          cmd_snake,
  output logic [PW-1:0] cmd_phase,
  output logic [SW-1:0] cmd_step
);

  // A mesh whose PE count disagrees with its side length never starts.
  localparam bit GEOM_OK = (N == SIDE * SIDE);

  sched_state_e  state;
  sched_state_e  state_nx;
  logic [SW-1:0] step_q;
  logic [PW-1:0] phase_q;
  logic          step_wrap;
  logic          phase_wrap;
  logic          xfer;
  logic          load;
  cmd_flags_t    flags;

  assign xfer = (state == RUN) && pe_ready;
  assign load = (state == IDLE) && start && GEOM_OK;

  mesh_wrap_cnt #(.MOD(SORT_CYCLES)) u_step (
    .clk  (clk),
    .rst  (rst),
    .en   (xfer),
    .clr  (load),
    .q    (step_q),
    .wrap (step_wrap)
  );

  // Phase wrap coincides with the transfer of the very last step.
  mesh_wrap_cnt #(.MOD(PHASES)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .en   (step_wrap),
    .clr  (load),
    .q    (phase_q),
    .wrap (phase_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    cmd_valid = 1'b0;
    flags     = '0;
    cmd_phase = '0;
    cmd_step  = '0;
    case (state)
      IDLE: begin
        if (load) state_nx = RUN;
      end
      RUN: begin
        busy        = 1'b1;
        cmd_valid   = 1'b1;
        flags.row   = phase_q[0] ? PHASE_COL : PHASE_ROW;
        flags.odd   = step_q[0];
        flags.snake = flags.row;
        cmd_phase   = phase_q;
        cmd_step    = step_q;
        if (phase_wrap) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_row   = flags.row;
  assign cmd_odd   = flags.odd;
  assign cmd_snake = flags.snake;

endmodule

// File: tb/tb_shear_sched.sv
// Self-checking bench for shear_sched: directed scenarios plus randomized
// start/pe_ready traffic against a command-list reference model.
module tb_shear_sched;

  localparam int unsigned SC    = 4;
  localparam int unsigned PH    = 3;
  localparam int unsigned TOTAL = PH * SC;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pe_ready;
  logic       busy, done, cmd_valid, cmd_row, cmd_odd, cmd_snake;
  logic [1:0] cmd_phase;
  logic [1:0] cmd_step;

  logic       start4;
  logic       busy4, done4, valid4, row4, odd4, snake4;
  logic [2:0] phase4;
  logic [1:0] step4;

  int n_cmp = 0;
  int n_err = 0;
  int m_mode;   // 0 idle, 1 issuing commands, 2 completion cycle
  int m_idx;    // index into the flattened phase-major command list
  int cyc, n_valid, n_done, done_at;
  int stalls, d_at, nxt_at, p, s;

  always #5 clk = ~clk;

  shear_sched #(.N(4), .SIDE(2), .SORT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cmd_valid (cmd_valid),
    .pe_ready  (pe_ready),
    .cmd_row   (cmd_row),
    .cmd_odd   (cmd_odd),
    .cmd_snake (cmd_snake),
    .cmd_phase (cmd_phase),
    .cmd_step  (cmd_step)
  );

  shear_sched #(.N(16), .SIDE(4), .SORT_CYCLES(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .busy      (busy4),
    .done      (done4),
    .cmd_valid (valid4),
    .pe_ready  (1'b1),
    .cmd_row   (row4),
    .cmd_odd   (odd4),
    .cmd_snake (snake4),
    .cmd_phase (phase4),
    .cmd_step  (step4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs: command m_idx is phase m_idx/SC, step m_idx%SC.
  task automatic check_model();
    int ph, st;
    logic [9:0] e;
    e  = '0;
    ph = m_idx / SC;
    st = m_idx % SC;
    if (m_mode == 1)
      e = {1'b1, 1'b0, 1'b1, (ph % 2 == 0), 1'(st % 2), (ph % 2 == 0), 2'(ph), 2'(st)};
    else if (m_mode == 2)
      e = {1'b1, 1'b1, 8'd0};
    chk("model", 32'({busy, done, cmd_valid, cmd_row, cmd_odd, cmd_snake, cmd_phase, cmd_step}),
        32'(e));
  endtask

  // Called at a falling edge: drive inputs, check, advance one cycle.
  task automatic tick(input logic st, input logic rdy);
    start    = st;
    pe_ready = rdy;
    check_model();
    @(posedge clk);
    case (m_mode)
      0: if (st) begin m_mode = 1; m_idx = 0; end
      1: if (rdy) begin
           if (m_idx == TOTAL - 1) m_mode = 2;
           else m_idx++;
         end
      default: m_mode = 0;
    endcase
    @(negedge clk);
    cyc++;
    if (cmd_valid) n_valid++;
    if (done) begin n_done++; done_at = cyc; end
  endtask

  task automatic clear_stats();
    cyc = 0; n_valid = 0; n_done = 0; done_at = -1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pe_ready = 1'b0; start4 = 1'b0;
    m_mode = 0; m_idx = 0;
    clear_stats();
    repeat (2) @(negedge clk);
    chk("reset_out", 32'({busy, done, cmd_valid, cmd_row, cmd_odd, cmd_snake, cmd_phase, cmd_step}), 32'd0);
    chk("reset_out4", 32'({busy4, done4, valid4, row4, odd4, snake4, phase4, step4}), 32'd0);
    rst = 1'b1;
    tick(1'b0, 1'b1);

    // Straight sort, pe_ready held high
    clear_stats();
    tick(1'b1, 1'b1);
    repeat (15) tick(1'b0, 1'b1);
    chk("t1_valid_cnt", 32'(n_valid), 32'd12);
    chk("t1_done_at", 32'(done_at), 32'd13);
    chk("t1_done_cnt", 32'(n_done), 32'd1);

    // Three-cycle stall at phase 1 step 2
    clear_stats();
    stalls = 0;
    tick(1'b1, 1'b1);
    repeat (20) begin
      if (m_mode == 1 && m_idx == 6 && stalls < 3) begin
        stalls++;
        chk("t2_hold", 32'({cmd_phase, cmd_step, cmd_odd}), 32'({2'd1, 2'd2, 1'b0}));
        tick(1'b0, 1'b0);
      end else begin
        tick(1'b0, 1'b1);
      end
    end
    chk("t2_done_at", 32'(done_at), 32'd16);
    chk("t2_valid_cnt", 32'(n_valid), 32'd15);

    // start re-pulsed mid-run is ignored
    clear_stats();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) tick(i == 4, 1'b1);
    chk("t3_valid_cnt", 32'(n_valid), 32'd12);
    chk("t3_done_cnt", 32'(n_done), 32'd1);
    chk("t3_done_at", 32'(done_at), 32'd13);

    // Asynchronous reset in phase 1, then a clean restart
    tick(1'b1, 1'b1);
    repeat (5) tick(1'b0, 1'b1);
    chk("t4_pre_phase", 32'(cmd_phase), 32'd1);
    rst = 1'b0;
    #1;
    chk("t4_async_clear", 32'({busy, done, cmd_valid, cmd_row, cmd_odd, cmd_snake, cmd_phase, cmd_step}), 32'd0);
    m_mode = 0; m_idx = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_stats();
    tick(1'b1, 1'b1);
    chk("t4_restart", 32'({cmd_valid, cmd_phase, cmd_step}), 32'({1'b1, 2'd0, 2'd0}));
    repeat (15) tick(1'b0, 1'b1);
    chk("t4_valid_cnt", 32'(n_valid), 32'd12);
    chk("t4_done_at", 32'(done_at), 32'd13);

    // 4x4 mesh: five phases, done 21 cycles after start
    start4 = 1'b1;
    tick(1'b0, 1'b1);
    start4 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      p = (k - 1) / 4;
      s = (k - 1) % 4;
      if (k <= 20)
        chk("n16_cmd", 32'({busy4, done4, valid4, row4, odd4, snake4, phase4, step4}),
            32'({1'b1, 1'b0, 1'b1, (p % 2 == 0), 1'(s % 2), (p % 2 == 0), 3'(p), 2'(s)}));
      else if (k == 21)
        chk("n16_done", 32'({busy4, done4, valid4, row4, odd4, snake4, phase4, step4}),
            32'({1'b1, 1'b1, 9'd0}));
      else
        chk("n16_idle", 32'({busy4, done4, valid4, row4, odd4, snake4, phase4, step4}), 32'd0);
      tick(1'b0, 1'b1);
    end

    // start held high: back-to-back sorts with one idle cycle between
    clear_stats();
    d_at = 0; nxt_at = 0;
    repeat (45) begin
      tick(1'b1, 1'b1);
      if (done && d_at == 0) d_at = cyc;
      if (cmd_valid && d_at > 0 && nxt_at == 0) nxt_at = cyc;
    end
    chk("t6_done_cnt", 32'(n_done), 32'd3);
    chk("t6_gap", 32'(nxt_at - d_at), 32'd2);
    repeat (20) tick(1'b0, 1'b1);

    // Randomized start pulses and back-pressure
    repeat (400) tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    repeat (50) tick(1'b0, 1'b1);
    chk("rand_idle_end", 32'({busy, cmd_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shear_sched.md
# shear_sched

Phase/step scheduler for the shear-sort mesh. On `start` it sequences the PE array through alternating row and column odd-even transposition phases, issuing one compare-exchange command per step over a valid/ready handshake, and pulses `done` after the final row phase. It sits beside `mesh`, broadcasting its command fields to every PE; the PEs' collective ready is ANDed externally into `pe_ready`.

## Interface
- `N`, 4: number of PEs (SIDE*SIDE).
- `SIDE`, 2: mesh side length, power of two, at least 2.
- `SORT_CYCLES`, 4: compare-exchange steps per phase, at least 1.
- `PHASES`, 2*$clog2(SIDE)+1: derived, not overridden; row phases at even indices, column phases at odd indices.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `start` in 1: begin a sort; sampled only in IDLE.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse when the sort completes.
- `cmd_valid` out 1: command fields valid.
- `pe_ready` in 1: all PEs accept the command this cycle.
- `cmd_row` out 1: 1 for a row phase, 0 for a column phase.
- `cmd_odd` out 1: step parity; 0 for even pairs (0-1, 2-3, ...), 1 for odd pairs.
- `cmd_snake` out 1: 1 in row phases (odd rows sort descending); 0 in column phases.
- `cmd_phase` out $clog2(PHASES): current phase index.
- `cmd_step` out $clog2(SORT_CYCLES) (min 1): current step index.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: all outputs 0. `start`=1 goes to RUN; `phase_cnt` and `step_cnt` load 0.
- RUN: `cmd_valid`=1. Fields come combinationally from the counters: `cmd_row`=~phase_cnt[0], `cmd_odd`=step_cnt[0], `cmd_snake`=`cmd_row`.
- Transfer occurs on an edge where `cmd_valid` and `pe_ready` are both 1. With `pe_ready`=0, all fields hold stable.
- On transfer, `step_cnt` increments. At SORT_CYCLES-1 it wraps to 0 and `phase_cnt` increments.
- A transfer at phase PHASES-1, step SORT_CYCLES-1 goes to DONE instead of incrementing.
- DONE lasts one cycle: `done`=1, `cmd_valid`=0, `busy`=1. It then returns to IDLE unconditionally.
- `start` is ignored in RUN and DONE. A `start` held high through DONE begins a new sort from the following IDLE cycle.
- `pe_ready` is ignored outside RUN.
- Reset asserted at any time, including mid-phase: state is IDLE and both counters are 0 immediately (asynchronous). All outputs are 0. No partial command is retried after reset release.

## Timing
- start-to-first-command: `start` is sampled at edge E, and `cmd_valid` is high in the cycle after E.
- Commands issue back-to-back with no bubbles while `pe_ready`=1.
- `done` is high in the cycle after the final transfer edge.
- Total from the start edge to `done`, with `pe_ready` always 1: PHASES*SORT_CYCLES+1 cycles.
- Each cycle of `pe_ready`=0 during RUN adds exactly one cycle.
- All outputs are registered state or simple decodes of state and counters. There is no combinational path from `pe_ready` or `start` to any output.

## Structure
- Shared package `mesh_pkg`:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - function `shear_phases(side)` returning 2*$clog2(side)+1;
  - parameters `PHASE_ROW`=1'b1 and `PHASE_COL`=1'b0, reused by the PE decode.
- One sub-module, `mesh_wrap_cnt`:
  - parameterised-modulus counter with `en`, `clr`, `q` and `wrap` (`wrap` high when en && q==MOD-1);
  - instantiated twice, for step and for phase.
- Remaining FSM plus decode: about 150 lines.

## Test plan
1. Default parameters, `pe_ready` tied 1, `start` pulsed:
   - 12 consecutive `cmd_valid` cycles;
   - (`cmd_phase`, `cmd_row`) = (0,1)x4, (1,0)x4, (2,1)x4;
   - `cmd_odd` = 0,1,0,1 within each phase;
   - `done` high exactly 13 cycles after the start edge.
2. `pe_ready` low for 3 cycles at phase 1, step 2: fields hold (`cmd_phase`=1, `cmd_step`=2, `cmd_odd`=0) and `done` is delayed to cycle 16.
3. `start` re-pulsed during RUN: no effect; still exactly 12 transfers and one `done` pulse.
4. `rst` driven 0 mid-phase 1: `cmd_valid`, `busy`, `done` and the counters read 0 before the next edge. After release and a new `start`, the sequence restarts at phase 0, step 0.
5. SIDE=4, SORT_CYCLES=4 (N=16): PHASES=5, 20 transfers, `done` 21 cycles after start, final phase `cmd_row`=1.
6. `start` held high continuously: sorts repeat with one IDLE cycle between `done` and the next `cmd_valid`.
